// File: rtl/d_mem.sv
// Word-addressed data memory for the MEM stage: synchronous write with a
// synchronous all-zero clear, combinational enable-gated read.
module d_mem #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned LOG_DEPTH_MEM = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LOG_DEPTH_MEM-1:0] dataAddress,
    input  logic [WIDTH-1:0]         writeMemData,
    input  logic                     memRead,
    input  logic                     memWrite,
    output logic [WIDTH-1:0]         readMemData
);

    localparam int unsigned Depth = 2 ** LOG_DEPTH_MEM;

    logic [WIDTH-1:0] memArray [Depth];

    // Clear wins over a same-edge write, so the write is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < Depth; i++) begin
                memArray[i] <= '0;
            end
        end else if (memWrite) begin
            memArray[dataAddress] <= writeMemData;
        end
    end

    // No write bypass: a same-cycle read sees the pre-edge contents.
    always_comb begin
        readMemData = '0;
        if (memRead) begin
            readMemData = memArray[dataAddress];
        end
    end

endmodule

// File: tb/tb_d_mem.sv
// Self-checking bench for d_mem: directed scenarios plus a randomized run
// against an array-based reference model.
module tb_d_mem;

    localparam int unsigned WIDTH         = 32;
    localparam int unsigned LOG_DEPTH_MEM = 8;
    localparam int unsigned DEPTH         = 2 ** LOG_DEPTH_MEM;

    logic                     clk;
    logic                     rst;
    logic [LOG_DEPTH_MEM-1:0] dataAddress;
    logic [WIDTH-1:0]         writeMemData;
    logic                     memRead;
    logic                     memWrite;
    logic [WIDTH-1:0]         readMemData;

    int compared;
    int mismatched;

    // Reference contents: what each word should hold after every edge.
    logic [WIDTH-1:0] model [DEPTH];

    d_mem #(
        .WIDTH        (WIDTH),
        .LOG_DEPTH_MEM(LOG_DEPTH_MEM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dataAddress (dataAddress),
        .writeMemData(writeMemData),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .readMemData (readMemData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, updating the model from the controls driven.
    task automatic tick();
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (memWrite) begin
            model[dataAddress] = writeMemData;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int addr, input logic [WIDTH-1:0] data);
        dataAddress  = addr[LOG_DEPTH_MEM-1:0];
        writeMemData = data;
        memWrite     = 1'b1;
        memRead      = 1'b0;
        tick();
        memWrite     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        memWrite = 1'b0;
        memRead = 1'b0;
        dataAddress = '0;
        writeMemData = '0;
        tick();
        #1;
        if (readMemData !== '0) begin
            $display("FAIL reset_out_disabled got=%h want=%h", readMemData, 32'h0);
            mismatched++;
        end
        compared++;
        rst = 1'b1;
        memRead = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            dataAddress = i[LOG_DEPTH_MEM-1:0];
            #1;
            if (readMemData !== 32'h0) begin
                $display("FAIL reset_all_zero addr=%0d got=%h want=%h", i, readMemData, 32'h0);
                mismatched++;
            end
            compared++;
        end
        // Clear after a write: address 5 must go back to 0.
        write_word(5, 32'hDEADBEEF);
        memRead = 1'b1;
        dataAddress = 8'd5;
        #1;
        if (readMemData !== 32'hDEADBEEF) begin
            $display("FAIL reset_prewrite got=%h want=%h", readMemData, 32'hDEADBEEF);
            mismatched++;
        end
        compared++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        if (readMemData !== 32'h0) begin
            $display("FAIL reset_clear got=%h want=%h", readMemData, 32'h0);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_write_read();
        write_word(8'h3A, 32'h12345678);
        memRead = 1'b1;
        dataAddress = 8'h3A;
        #1;
        if (readMemData !== 32'h12345678) begin
            $display("FAIL write_read got=%h want=%h", readMemData, 32'h12345678);
            mismatched++;
        end
        compared++;
        dataAddress = 8'h3B;
        #1;
        if (readMemData !== 32'h0) begin
            $display("FAIL untouched_neighbor got=%h want=%h", readMemData, 32'h0);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_read_disable();
        memRead = 1'b0;
        dataAddress = 8'h3A;
        #1;
        if (readMemData !== 32'h0) begin
            $display("FAIL read_disabled got=%h want=%h", readMemData, 32'h0);
            mismatched++;
        end
        compared++;
        memRead = 1'b1;
        #1;
        if (readMemData !== 32'h12345678) begin
            $display("FAIL read_enable_same_cycle got=%h want=%h", readMemData, 32'h12345678);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_simultaneous();
        write_word(7, 32'h11);
        dataAddress = 8'd7;
        writeMemData = 32'h22;
        memRead = 1'b1;
        memWrite = 1'b1;
        #1;
        if (readMemData !== 32'h11) begin
            $display("FAIL rw_before_edge got=%h want=%h", readMemData, 32'h11);
            mismatched++;
        end
        compared++;
        tick();
        memWrite = 1'b0;
        #1;
        if (readMemData !== 32'h22) begin
            $display("FAIL rw_after_edge got=%h want=%h", readMemData, 32'h22);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_reset_vs_write();
        write_word(9, 32'h55);
        rst = 1'b0;
        memWrite = 1'b1;
        dataAddress = 8'd9;
        writeMemData = 32'hFF;
        tick();
        rst = 1'b1;
        memWrite = 1'b0;
        memRead = 1'b1;
        #1;
        if (readMemData !== 32'h0) begin
            $display("FAIL reset_beats_write got=%h want=%h", readMemData, 32'h0);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_boundaries();
        write_word(0, 32'hA5A5_0001);
        write_word(DEPTH - 1, 32'h5A5A_FFFE);
        memRead = 1'b1;
        dataAddress = '0;
        #1;
        if (readMemData !== 32'hA5A5_0001) begin
            $display("FAIL boundary_low got=%h want=%h", readMemData, 32'hA5A5_0001);
            mismatched++;
        end
        compared++;
        dataAddress = '1;
        #1;
        if (readMemData !== 32'h5A5A_FFFE) begin
            $display("FAIL boundary_high got=%h want=%h", readMemData, 32'h5A5A_FFFE);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] expected;
        for (int n = 0; n < 2000; n++) begin
            int unsigned pick;
            pick = $urandom_range(0, 9);
            if (pick == 0) dataAddress = '0;
            else if (pick == 1) dataAddress = '1;
            else dataAddress = LOG_DEPTH_MEM'($urandom_range(0, 15));
            writeMemData = $urandom();
            memRead  = 1'($urandom_range(0, 1));
            memWrite = 1'($urandom_range(0, 1));
            rst      = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            #1;
            expected = memRead ? model[dataAddress] : '0;
            if (readMemData !== expected) begin
                $display("FAIL random_read iter=%0d addr=%0d got=%h want=%h",
                         n, dataAddress, readMemData, expected);
                mismatched++;
            end
            compared++;
            tick();
        end
        rst = 1'b1;
        memWrite = 1'b0;
        memRead = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dataAddress = i[LOG_DEPTH_MEM-1:0];
            #1;
            if (readMemData !== model[i]) begin
                $display("FAIL random_final addr=%0d got=%h want=%h", i, readMemData, model[i]);
                mismatched++;
            end
            compared++;
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = 'x;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_read_disable();
        test_simultaneous();
        test_reset_vs_write();
        test_boundaries();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
